// File: rtl/params_pkg.sv
// Shared types and default sizes for the fetch-side instruction memory.
package params_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_SIZE   = 256;

  typedef logic [DATA_WIDTH-1:0] instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_resp_state_t;
endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction array: registered read on enable, one write port.
// Both ports share the same edge, so a same-word read sees the pre-write contents.
module imem_ram #(
  parameter int IMEM_WORDS = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(IMEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);
  logic [DATA_WIDTH-1:0] mem [IMEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem[rd_idx_i];
  end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory slave for the fetch stage: fixed-latency reads, one pending slot,
// and a program-load write port.
//   state | meaning
//   IDLE  | no access in flight, pending slot empty
//   WAIT  | access in flight, counting down to the response
//   RESP  | response cycle; next access may start here
module imem_responder
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_WORDS = 256,
  parameter int LATENCY    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_pc_i,
  output logic                  instr_valid_o,
  output instruction_t          instr_o,
  output logic                  busy_o,
  output logic                  drop_o,
  input  logic                  load_en_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i
);
  localparam int IDX_W = $clog2(IMEM_WORDS);

  imem_resp_state_t      state;
  logic [3:0]            cnt;
  logic                  pend_valid;
  logic [IDX_W-1:0]      pend_idx;
  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  take_pend;
  logic                  accept;
  logic [DATA_WIDTH-1:0] ram_data;
  instruction_t          last_instr;
  logic                  unused_addr_bits;

  assign req_idx   = req_pc_i[IDX_W+1:2];
  assign wr_idx    = load_addr_i[IDX_W+1:2];
  assign take_pend = (state == RESP) && pend_valid;
  assign accept    = take_pend || (((state == IDLE) || (state == RESP)) && req_valid_i);
  assign rd_idx    = take_pend ? pend_idx : req_idx;

  // The RAM read register is the captured word; instr_o falls back to the copy
  // taken in the response cycle so it holds until the next response.
  assign instr_o = instr_valid_o ? instruction_t'(ram_data) : last_instr;

  assign unused_addr_bits = ^{req_pc_i[ADDR_WIDTH-1:IDX_W+2], req_pc_i[1:0],
                              load_addr_i[ADDR_WIDTH-1:IDX_W+2], load_addr_i[1:0]};

  imem_ram #(
    .IMEM_WORDS (IMEM_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .rd_en_i   (accept && rst_i),
    .rd_idx_i  (rd_idx),
    .rd_data_o (ram_data),
    .wr_en_i   (load_en_i && rst_i),
    .wr_idx_i  (wr_idx),
    .wr_data_i (load_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      pend_valid    <= 1'b0;
      pend_idx      <= '0;
      instr_valid_o <= 1'b0;
      drop_o        <= 1'b0;
      busy_o        <= 1'b0;
      last_instr    <= '0;
    end else begin
      instr_valid_o <= 1'b0;
      drop_o        <= 1'b0;
      if (instr_valid_o) last_instr <= instruction_t'(ram_data);

      if (accept) begin
        cnt    <= 4'(LATENCY - 1);
        busy_o <= 1'b1;
        if (LATENCY == 1) begin
          state         <= RESP;
          instr_valid_o <= 1'b1;
        end else begin
          state <= WAIT;
        end
      end

      case (state)
        IDLE: ;
        WAIT: begin
          if (req_valid_i) begin
            if (pend_valid) begin
              drop_o <= 1'b1;
            end else begin
              pend_valid <= 1'b1;
              pend_idx   <= req_idx;
            end
          end
          if (cnt == 4'd1) begin
            state         <= RESP;
            instr_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Slot is judged full for the whole response cycle, even as it drains.
          if (pend_valid) begin
            pend_valid <= 1'b0;
            drop_o     <= req_valid_i;
          end else if (!req_valid_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=3 and LATENCY=1 instances, each checked every
// cycle against a timestamp-based model, plus literal checks from the test plan.
module tb_imem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_v   [2];
  logic [31:0] req_pc  [2];
  logic        ld_en   [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_data [2];
  logic        v_o     [2];
  logic        busy_o  [2];
  logic        drop_o  [2];
  logic [31:0] instr_o [2];

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  imem_responder #(.LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_v[0]), .req_pc_i(req_pc[0]),
    .instr_valid_o(v_o[0]), .instr_o(instr_o[0]), .busy_o(busy_o[0]), .drop_o(drop_o[0]),
    .load_en_i(ld_en[0]), .load_addr_i(ld_addr[0]), .load_data_i(ld_data[0])
  );

  imem_responder #(.LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_v[1]), .req_pc_i(req_pc[1]),
    .instr_valid_o(v_o[1]), .instr_o(instr_o[1]), .busy_o(busy_o[1]), .drop_o(drop_o[1]),
    .load_en_i(ld_en[1]), .load_addr_i(ld_addr[1]), .load_data_i(ld_data[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each access is a timestamp (the cycle its response is due).
  int          cyc = 0;
  int          resp_at [2];
  bit          pend_v  [2];
  int          pend_w  [2];
  logic [31:0] cur     [2];
  logic [31:0] mem_m   [2][256];
  logic        exp_v   [2];
  logic        exp_busy[2];
  logic        exp_drop[2];
  logic [31:0] exp_instr[2];

  function automatic int lat(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 32'd256);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      resp_at[k] = -1; pend_v[k] = 0; pend_w[k] = 0; cur[k] = '0;
      exp_v[k] = 0; exp_busy[k] = 0; exp_drop[k] = 0; exp_instr[k] = '0;
      for (int w = 0; w < 256; w++) mem_m[k][w] = '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          resp_at[k] = -1; pend_v[k] = 0;
          exp_v[k] = 0; exp_busy[k] = 0; exp_drop[k] = 0; exp_instr[k] = '0;
        end else begin
          exp_drop[k] = 0;
          if (resp_at[k] < 0 || resp_at[k] == cyc) begin
            if (pend_v[k]) begin
              cur[k] = mem_m[k][pend_w[k]];
              resp_at[k] = cyc + lat(k);
              pend_v[k] = 0;
              if (req_v[k]) exp_drop[k] = 1;
            end else if (req_v[k]) begin
              cur[k] = mem_m[k][widx(req_pc[k])];
              resp_at[k] = cyc + lat(k);
            end else begin
              resp_at[k] = -1;
            end
          end else if (req_v[k]) begin
            if (pend_v[k]) exp_drop[k] = 1;
            else begin
              pend_v[k] = 1;
              pend_w[k] = widx(req_pc[k]);
            end
          end
          if (ld_en[k]) mem_m[k][widx(ld_addr[k])] = ld_data[k];
          exp_v[k] = (resp_at[k] == cyc + 1);
          if (exp_v[k]) exp_instr[k] = cur[k];
          exp_busy[k] = (resp_at[k] >= 0) || pend_v[k];
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int k = 0; k < 2; k++) begin
          string nm;
          nm = (k == 0) ? "lat3" : "lat1";
          chk({nm, ".valid"}, 32'(v_o[k]), 32'(exp_v[k]));
          chk({nm, ".busy"},  32'(busy_o[k]), 32'(exp_busy[k]));
          chk({nm, ".drop"},  32'(drop_o[k]), 32'(exp_drop[k]));
          chk({nm, ".instr"}, instr_o[k], exp_instr[k]);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_v[0] = 0; req_v[1] = 0; ld_en[0] = 0; ld_en[1] = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load(int k, logic [31:0] a, logic [31:0] d);
    ld_en[k] = 1; ld_addr[k] = a; ld_data[k] = d;
    @(negedge clk);
    ld_en[k] = 0;
  endtask

  initial begin
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 0; req_pc[k] = '0; ld_en[k] = 0; ld_addr[k] = '0; ld_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_en = 1;
    chk("reset.instr", instr_o[0], 32'h0);
    chk("reset.busy", 32'(busy_o[0]), 32'h0);
    chk("reset.valid", 32'(v_o[0]), 32'h0);
    rst = 1;

    load(0, 32'h10, 32'h00A00093);
    load(0, 32'h0, 32'hC0DE0000);
    load(0, 32'h4, 32'hC0DE0001);
    load(0, 32'h8, 32'hC0DE0002);
    load(1, 32'h0, 32'hAAAA0000);
    load(1, 32'h4, 32'hAAAA0001);
    load(1, 32'h8, 32'hAAAA0002);

    // single request, LATENCY=3
    req_v[0] = 1; req_pc[0] = 32'h10; nxt();
    req_v[0] = 0; chk("s1.t1.valid", 32'(v_o[0]), 32'h0); nxt();
    chk("s1.t2.valid", 32'(v_o[0]), 32'h0); nxt();
    chk("s1.t3.valid", 32'(v_o[0]), 32'h1);
    chk("s1.t3.instr", instr_o[0], 32'h00A00093); nxt();
    chk("s1.t4.valid", 32'(v_o[0]), 32'h0);
    chk("s1.t4.busy", 32'(busy_o[0]), 32'h0);
    chk("s1.t4.hold", instr_o[0], 32'h00A00093);
    idle(2);

    // back-to-back, LATENCY=1
    req_v[1] = 1; req_pc[1] = 32'h0; nxt();
    chk("s2.r0", instr_o[1], 32'hAAAA0000); chk("s2.v0", 32'(v_o[1]), 32'h1);
    req_pc[1] = 32'h4; nxt();
    chk("s2.r1", instr_o[1], 32'hAAAA0001); chk("s2.v1", 32'(v_o[1]), 32'h1);
    req_pc[1] = 32'h8; nxt();
    chk("s2.r2", instr_o[1], 32'hAAAA0002); chk("s2.v2", 32'(v_o[1]), 32'h1);
    chk("s2.drop", 32'(drop_o[1]), 32'h0);
    req_v[1] = 0; nxt();
    chk("s2.v3", 32'(v_o[1]), 32'h0);
    idle(2);

    // pending slot fill and drop, LATENCY=3
    req_v[0] = 1; req_pc[0] = 32'h0; nxt();
    req_pc[0] = 32'h4; nxt();
    req_pc[0] = 32'h8; nxt();
    req_v[0] = 0;
    chk("s3.t3.valid", 32'(v_o[0]), 32'h1);
    chk("s3.t3.instr", instr_o[0], 32'hC0DE0000);
    chk("s3.t3.drop", 32'(drop_o[0]), 32'h1); nxt();
    chk("s3.t4.drop", 32'(drop_o[0]), 32'h0); nxt(); nxt();
    chk("s3.t6.valid", 32'(v_o[0]), 32'h1);
    chk("s3.t6.instr", instr_o[0], 32'hC0DE0001);
    idle(4);

    // address wrap
    req_v[0] = 1; req_pc[0] = 32'h403; nxt();
    req_v[0] = 0; nxt(); nxt();
    chk("s4.wrap", instr_o[0], 32'hC0DE0000);
    idle(3);

    // write after acceptance does not affect the in-flight access
    load(0, 32'h20, 32'h11111111);
    req_v[0] = 1; req_pc[0] = 32'h20; nxt();
    req_v[0] = 0; ld_en[0] = 1; ld_addr[0] = 32'h20; ld_data[0] = 32'h22222222; nxt();
    ld_en[0] = 0; nxt();
    chk("s5.old", instr_o[0], 32'h11111111);
    idle(2);
    req_v[0] = 1; req_pc[0] = 32'h20; nxt();
    req_v[0] = 0; nxt(); nxt();
    chk("s5.new", instr_o[0], 32'h22222222);
    idle(2);

    // same-cycle read and write, LATENCY=1
    load(1, 32'h40, 32'h33333333);
    req_v[1] = 1; req_pc[1] = 32'h40;
    ld_en[1] = 1; ld_addr[1] = 32'h40; ld_data[1] = 32'h44444444; nxt();
    req_v[1] = 0; ld_en[1] = 0;
    chk("s5.rbw", instr_o[1], 32'h33333333);
    idle(2);

    // reset during WAIT, with a load attempted while in reset
    req_v[0] = 1; req_pc[0] = 32'h10; nxt();
    req_v[0] = 0; rst = 0;
    ld_en[1] = 1; ld_addr[1] = 32'h40; ld_data[1] = 32'hDEADBEEF; nxt();
    rst = 1; ld_en[1] = 0;
    chk("s6.busy", 32'(busy_o[0]), 32'h0);
    chk("s6.instr", instr_o[0], 32'h0); nxt(); nxt();
    chk("s6.noresp", 32'(v_o[0]), 32'h0);
    idle(2);
    req_v[1] = 1; req_pc[1] = 32'h40; nxt();
    req_v[1] = 0;
    chk("s6.ldignored", instr_o[1], 32'h44444444);
    idle(1);
    req_v[0] = 1; req_pc[0] = 32'h10; nxt();
    req_v[0] = 0; nxt(); nxt();
    chk("s6.ramkept", instr_o[0], 32'h00A00093);
    idle(3);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
